// File: rtl/rotary_pkg.sv
// rotary_pkg
//   Shared definitions for the rotary encoder decoder.
//   - Gray state constants for the filtered {A,B} contact pair.
//   - Direction encoding produced by the transition decoder.
//   - decodeStep(): maps a {previous, current} filtered pair to a direction or illegal.
package rotary_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_LEFT    = 2'd1,
    DIR_RIGHT   = 2'd2,
    DIR_ILLEGAL = 2'd3
  } rotaryDir_t;

  // Successor of a state when turning right: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] nextRight(input logic [1:0] s);
    case (s)
      S00:     nextRight = S10;
      S10:     nextRight = S11;
      S11:     nextRight = S01;
      default: nextRight = S00;
    endcase
  endfunction

  // A left move is a right move seen backwards; anything that is neither
  // (both bits flipped) is illegal.
  function automatic rotaryDir_t decodeStep(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                 return DIR_NONE;
    else if (cur == nextRight(prev)) return DIR_RIGHT;
    else if (prev == nextRight(cur)) return DIR_LEFT;
    else                             return DIR_ILLEGAL;
  endfunction

endpackage

// File: rtl/rotary_debounce.sv
// rotary_debounce
//   One encoder contact: two-flop synchroniser followed by a debounce filter.
//   The filtered value follows the synchronised input only after it has
//   differed for DEBOUNCE_CYCLES consecutive sampled cycles.
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   rawIn    in   raw contact, asynchronous to clock
//   filtered out  debounced contact value
module rotary_debounce
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic rawIn,
  output logic filtered
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          syncMeta;
  logic          syncOut;
  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
      filtered <= 1'b0;
      count    <= '0;
    end else begin
      syncMeta <= rawIn;
      syncOut  <= syncMeta;
      if (syncOut == filtered) begin
        count <= '0;
      end else if (count == LAST) begin
        // Differed for DEBOUNCE_CYCLES samples in a row (this one included).
        filtered <= syncOut;
        count    <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rotary_decoder.sv
// rotary_decoder
//   Quadrature decoder for a mechanical rotary encoder: synchronises and
//   debounces both contacts, decodes the Gray sequence into a sub-step
//   accumulator, emits one-cycle left/right pulses every STEPS_PER_DETENT
//   transitions and keeps a wrapping or saturating position counter.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   rotary[1:0]  in   raw contacts {A,B}
//   clear        in   synchronous clear of position and accumulator
//   rotary_left  out  one-cycle pulse per left step
//   rotary_right out  one-cycle pulse per right step
//   error        out  one-cycle pulse when both filtered bits change together
//   position     out  unsigned step count (right +1, left -1)
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int STEPS_PER_DETENT = 4,
  parameter int COUNT_WIDTH      = 8,
  parameter int WRAP             = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             rotary,
  input  logic                   clear,
  output logic                   rotary_left,
  output logic                   rotary_right,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] position
);

  localparam logic signed [3:0] ACC_TOP = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] ACC_BOT = 4'(-STEPS_PER_DETENT);

  logic [1:0]        filt;
  logic [1:0]        prevFilt;
  logic signed [3:0] accum;
  logic signed [3:0] accNext;
  rotaryDir_t        dir;

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) debounceA (
    .clock    (clock),
    .reset    (reset),
    .rawIn    (rotary[1]),
    .filtered (filt[1])
  );

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) debounceB (
    .clock    (clock),
    .reset    (reset),
    .rawIn    (rotary[0]),
    .filtered (filt[0])
  );

  assign dir = decodeStep(prevFilt, filt);

  // Reversal mid-detent walks the accumulator back, so a half-turn and
  // return never reaches either threshold.
  always_comb begin
    accNext = accum;
    if (dir == DIR_RIGHT)     accNext = accum + 4'sd1;
    else if (dir == DIR_LEFT) accNext = accum - 4'sd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prevFilt     <= S00;
      accum        <= '0;
      position     <= '0;
      rotary_left  <= 1'b0;
      rotary_right <= 1'b0;
      error        <= 1'b0;
    end else begin
      prevFilt     <= filt;
      error        <= (dir == DIR_ILLEGAL);
      rotary_left  <= 1'b0;
      rotary_right <= 1'b0;
      accum        <= accNext;
      if (accNext == ACC_TOP) begin
        rotary_right <= 1'b1;
        accum        <= '0;
        if (WRAP != 0 || position != '1) position <= position + COUNT_WIDTH'(1);
      end else if (accNext == ACC_BOT) begin
        rotary_left <= 1'b1;
        accum       <= '0;
        if (WRAP != 0 || position != '0) position <= position - COUNT_WIDTH'(1);
      end
      // Clear overrides the count but leaves any pulse above intact.
      if (clear) begin
        position <= '0;
        accum    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rotary_decoder.sv
// tb_rotary_decoder
//   Four decoder configurations share one stimulus stream. A behavioural
//   model (run-length debounce, Gray index arithmetic, integer accumulator
//   and position) is compared against every DUT on every cycle; directed
//   table entries and hand-written sequences check pulse counts, latency,
//   wrap/saturate, clear collision and asynchronous reset.
`timescale 1ns/1ps
module tb_rotary_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] rotary = 2'b00;

  always #5 clock = ~clock;

  logic       lA, rA, eA, lB, rB, eB, lC, rC, eC, lD, rD, eD;
  logic [7:0] posA, posD;
  logic [3:0] posB, posC;
  logic       lft [4];
  logic       rgt [4];
  logic       err [4];
  logic [7:0] posArr [4];

  assign lft[0] = lA; assign lft[1] = lB; assign lft[2] = lC; assign lft[3] = lD;
  assign rgt[0] = rA; assign rgt[1] = rB; assign rgt[2] = rC; assign rgt[3] = rD;
  assign err[0] = eA; assign err[1] = eB; assign err[2] = eC; assign err[3] = eD;
  assign posArr[0] = posA;
  assign posArr[1] = {4'b0000, posB};
  assign posArr[2] = {4'b0000, posC};
  assign posArr[3] = posD;

  rotary_decoder #(.DEBOUNCE_CYCLES(4), .STEPS_PER_DETENT(4), .COUNT_WIDTH(8), .WRAP(1)) dutA (
    .clock(clock), .reset(reset), .rotary(rotary), .clear(clear),
    .rotary_left(lA), .rotary_right(rA), .error(eA), .position(posA));
  rotary_decoder #(.DEBOUNCE_CYCLES(4), .STEPS_PER_DETENT(1), .COUNT_WIDTH(4), .WRAP(1)) dutB (
    .clock(clock), .reset(reset), .rotary(rotary), .clear(clear),
    .rotary_left(lB), .rotary_right(rB), .error(eB), .position(posB));
  rotary_decoder #(.DEBOUNCE_CYCLES(4), .STEPS_PER_DETENT(1), .COUNT_WIDTH(4), .WRAP(0)) dutC (
    .clock(clock), .reset(reset), .rotary(rotary), .clear(clear),
    .rotary_left(lC), .rotary_right(rC), .error(eC), .position(posC));
  rotary_decoder #(.DEBOUNCE_CYCLES(1), .STEPS_PER_DETENT(2), .COUNT_WIDTH(8), .WRAP(0)) dutD (
    .clock(clock), .reset(reset), .rotary(rotary), .clear(clear),
    .rotary_left(lD), .rotary_right(rD), .error(eD), .position(posD));

  int cfgD    [4] = '{4, 4, 4, 1};
  int cfgS    [4] = '{4, 1, 1, 2};
  int cfgW    [4] = '{8, 4, 4, 8};
  int cfgWrap [4] = '{1, 1, 0, 0};

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural reference model ----------------
  logic [1:0] rawHist [2];
  int         run  [4][2];
  logic [1:0] mFilt [4];
  logic [1:0] mPrev [4];
  int         mAcc [4];
  int         mPos [4];
  logic       mL [4];
  logic       mR [4];
  logic       mE [4];

  // Position of a Gray state around the right-turn cycle 00,10,11,01.
  function automatic int gIdx(input logic [1:0] s);
    return s[1] ? (s[0] ? 2 : 1) : (s[0] ? 3 : 0);
  endfunction

  function automatic logic [1:0] fromIdx(input int i);
    logic [1:0] t [4];
    t[0] = 2'b00; t[1] = 2'b10; t[2] = 2'b11; t[3] = 2'b01;
    return t[i % 4];
  endfunction

  task automatic modelReset();
    rawHist[0] = 2'b00;
    rawHist[1] = 2'b00;
    for (int c = 0; c < 4; c++) begin
      run[c][0] = 0; run[c][1] = 0;
      mFilt[c] = 2'b00; mPrev[c] = 2'b00;
      mAcc[c] = 0; mPos[c] = 0;
      mL[c] = 1'b0; mR[c] = 1'b0; mE[c] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    logic [1:0] seen;
    seen = rawHist[1];            // the contact value two edges ago
    rawHist[1] = rawHist[0];
    rawHist[0] = rotary;
    for (int c = 0; c < 4; c++) begin
      int d;
      int maxPos;
      logic [1:0] nf;
      d = (gIdx(mFilt[c]) - gIdx(mPrev[c]) + 4) % 4;
      nf = mFilt[c];
      for (int b = 0; b < 2; b++) begin
        if (seen[b] != mFilt[c][b]) begin
          run[c][b]++;
          if (run[c][b] >= cfgD[c]) begin
            nf[b] = seen[b];
            run[c][b] = 0;
          end
        end else begin
          run[c][b] = 0;
        end
      end
      mPrev[c] = mFilt[c];
      mFilt[c] = nf;
      mL[c] = 1'b0; mR[c] = 1'b0;
      mE[c] = (d == 2);
      if (d == 1) mAcc[c]++;
      if (d == 3) mAcc[c]--;
      maxPos = (1 << cfgW[c]) - 1;
      if (mAcc[c] == cfgS[c]) begin
        mR[c] = 1'b1; mAcc[c] = 0;
        if (mPos[c] < maxPos) mPos[c]++;
        else if (cfgWrap[c] != 0) mPos[c] = 0;
      end else if (mAcc[c] == -cfgS[c]) begin
        mL[c] = 1'b1; mAcc[c] = 0;
        if (mPos[c] > 0) mPos[c]--;
        else if (cfgWrap[c] != 0) mPos[c] = maxPos;
      end
      if (clear) begin
        mPos[c] = 0;
        mAcc[c] = 0;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  int segR [4];
  int segL [4];
  int segE [4];
  int firstPulse [4];
  int segTick;

  task automatic clearSeg();
    segTick = 0;
    for (int c = 0; c < 4; c++) begin
      segR[c] = 0; segL[c] = 0; segE[c] = 0; firstPulse[c] = -1;
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic checkAll();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({lft[c], rgt[c], err[c], posArr[c]} !== {mL[c], mR[c], mE[c], 8'(mPos[c])}) begin
        failures++;
        $display("FAIL model dut%0d t=%0t: got L=%b R=%b E=%b pos=%0d want L=%b R=%b E=%b pos=%0d",
                 c, $time, lft[c], rgt[c], err[c], posArr[c], mL[c], mR[c], mE[c], mPos[c]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) modelReset();
    else modelEdge();
    #1;
    checkAll();
    segTick++;
    for (int c = 0; c < 4; c++) begin
      if (rgt[c]) segR[c]++;
      if (lft[c]) segL[c]++;
      if (err[c]) segE[c]++;
      if ((rgt[c] || lft[c] || err[c]) && firstPulse[c] < 0) firstPulse[c] = segTick;
    end
  endtask

  // ---------------- directed table (expectations for dutA) ----------------
  typedef struct {
    logic [1:0] rot;
    int hold;
    int expR;
    int expL;
    int expE;
    int expPos;
    int expLat;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic [1:0] rot, input int hold, input int r, input int l,
                              input int e, input int p, input int lat);
    vec_t v;
    v.rot = rot; v.hold = hold; v.expR = r; v.expL = l; v.expE = e; v.expPos = p; v.expLat = lat;
    return v;
  endfunction

  initial begin
    logic [1:0] cur;

    // clean right detent
    vecs.push_back(mk(2'b10, 10, 0, 0, 0, 0, -1));
    vecs.push_back(mk(2'b11, 10, 0, 0, 0, 0, -1));
    vecs.push_back(mk(2'b01, 10, 0, 0, 0, 0, -1));
    vecs.push_back(mk(2'b00, 10, 1, 0, 0, 1, 7));
    // 3-cycle glitches never reach the filter
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(2'b01, 3, 0, 0, 0, 1, -1));
      vecs.push_back(mk(2'b00, 5, 0, 0, 0, 1, -1));
    end
    // real left detent (first transition leaves accumulator at -1)
    vecs.push_back(mk(2'b01, 10, 0, 0, 0, 1, -1));
    vecs.push_back(mk(2'b11, 10, 0, 0, 0, 1, -1));
    vecs.push_back(mk(2'b10, 10, 0, 0, 0, 1, -1));
    vecs.push_back(mk(2'b00, 10, 0, 1, 0, 0, 7));
    // half-turn and back
    vecs.push_back(mk(2'b10, 10, 0, 0, 0, 0, -1));
    vecs.push_back(mk(2'b11, 10, 0, 0, 0, 0, -1));
    vecs.push_back(mk(2'b10, 10, 0, 0, 0, 0, -1));
    vecs.push_back(mk(2'b00, 10, 0, 0, 0, 0, -1));
    // illegal double-bit jumps
    vecs.push_back(mk(2'b11, 10, 0, 0, 1, 0, 7));
    vecs.push_back(mk(2'b00, 10, 0, 0, 1, 0, 7));

    // ---- reset held with contacts at 11, then released ----
    modelReset();
    reset = 1'b0;
    rotary = 2'b11;
    repeat (3) tick();
    reset = 1'b1;
    clearSeg();
    repeat (12) tick();
    chk("reset-hold errors", segE[0], 1);
    chk("reset-hold error latency", firstPulse[0], 7);
    chk("reset-hold steps", segR[0] + segL[0], 0);
    chk("reset-hold position", int'(posA), 0);

    // back to a clean 00 start
    reset = 1'b0;
    rotary = 2'b00;
    repeat (2) tick();
    reset = 1'b1;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      rotary = vecs[i].rot;
      clearSeg();
      repeat (vecs[i].hold) tick();
      chk($sformatf("vec%0d right", i), segR[0], vecs[i].expR);
      chk($sformatf("vec%0d left", i), segL[0], vecs[i].expL);
      chk($sformatf("vec%0d error", i), segE[0], vecs[i].expE);
      chk($sformatf("vec%0d position", i), int'(posA), vecs[i].expPos);
      chk($sformatf("vec%0d latency", i), firstPulse[0], vecs[i].expLat);
    end

    // ---- wrap vs saturate on one left step from 0 ----
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear posB", int'(posB), 0);
    chk("clear posC", int'(posC), 0);
    rotary = 2'b01;
    clearSeg();
    repeat (10) tick();
    chk("wrap left pulse", segL[1], 1);
    chk("wrap position", int'(posB), 15);
    chk("saturate left pulse", segL[2], 1);
    chk("saturate position", int'(posC), 0);

    // ---- clear colliding with a step at position 5 ----
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rotary = fromIdx(3 + 1 + i);   // 00,10,11,01,00 : right moves from 01
      repeat (10) tick();
    end
    chk("pre-collision position", int'(posB), 5);
    rotary = 2'b10;
    repeat (6) tick();
    chk("pulse not yet", int'(rB), 0);
    chk("position not yet", int'(posB), 5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("collision pulse", int'(rB), 1);
    chk("collision position", int'(posB), 0);

    // ---- asynchronous reset mid-sequence at filtered 11 ----
    rotary = 2'b11;
    repeat (7) tick();
    chk("pre-reset pulse", int'(rB), 1);
    chk("pre-reset position", int'(posB), 1);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    chk("async reset outputs", int'({lA, rA, eA, lB, rB, eB, lC, rC, eC, lD, rD, eD}), 0);
    chk("async reset positions", int'(posA) + int'(posB) + int'(posC) + int'(posD), 0);
    rotary = 2'b00;
    repeat (2) tick();
    reset = 1'b1;

    // ---- randomised walk, mostly legal moves with bounce and clears ----
    cur = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        cur = fromIdx(gIdx(cur) + (($urandom_range(0, 1) != 0) ? 1 : 3));
      else
        cur = 2'($urandom_range(0, 3));
      rotary = cur;
      clear = ($urandom_range(0, 19) == 0);
      tick();
      clear = 1'b0;
      repeat ($urandom_range(0, 9)) tick();
    end
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
